// File: rtl/ledstrip_glyph_if.sv
// Character handshake between the ledstrip register block and the glyph transmitter.
// Latency: none, this is wiring only.
// Backpressure: the producer holds char_valid until it sees char_ready high.
interface ledstrip_glyph_if;
    logic [6:0]  char_in;
    logic        char_last;
    logic        char_valid;
    logic        char_ready;
    logic [23:0] color_grb;

    modport master (
        output char_in, char_last, char_valid, color_grb,
        input  char_ready
    );

    modport slave (
        input  char_in, char_last, char_valid, color_grb,
        output char_ready
    );
endinterface

// File: rtl/ledstrip_glyph_tx.sv
// Serialises one 5x7 glyph (35 GRB pixels) to a WS2812-style strip, optionally followed by a latch gap.
// Latency: 1 accept + 1 fetch cycle, then 840*BIT_CYC cycles of bits (+RST_CYC when last is set).
// Backpressure: char_ready is high only in IDLE; valid while busy is ignored and nothing is queued.
module ledstrip_glyph_tx #(
    parameter int T0H_CYC = 22,
    parameter int T1H_CYC = 45,
    parameter int BIT_CYC = 80,
    parameter int RST_CYC = 5120
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ledstrip_glyph_if.slave      chr,
    output logic [6:0]           rom_addr,
    input  logic [34:0]          rom_data,
    output logic                 led_out,
    output logic                 busy
);
    localparam int CNT_MAX = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] T0H_V     = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_V     = CW'(T1H_CYC);
    localparam logic [CW-1:0] BIT_END_V = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] RST_END_V = CW'(RST_CYC - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

    state_t          state;
    logic            last;
    logic [23:0]     color;
    logic [34:0]     glyph;
    logic [5:0]      pix_cnt;
    logic [4:0]      bit_cnt;
    logic [CW-1:0]   cyc_cnt;

    logic [23:0]     cur_word;
    logic            cur_bit;
    logic [CW-1:0]   hi_lim;
    logic            bit_end;

    // Current pixel word, current bit (MSB first) and its high-time threshold.
    always_comb begin
        cur_word = glyph[0] ? color : 24'h0;
        cur_bit  = cur_word[bit_cnt];
        hi_lim   = cur_bit ? T1H_V : T0H_V;
        bit_end  = (cyc_cnt == BIT_END_V);
    end

    // Glyph FSM: accept, fetch bitmap, shift out 35x24 bits, optional latch low period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            led_out        <= 1'b0;
            chr.char_ready <= 1'b1;
            busy           <= 1'b0;
            rom_addr       <= 7'd0;
            last           <= 1'b0;
            color          <= 24'h0;
            glyph          <= 35'h0;
            pix_cnt        <= 6'd0;
            bit_cnt        <= 5'd0;
            cyc_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    led_out <= 1'b0;
                    if (chr.char_valid && chr.char_ready) begin
                        rom_addr       <= chr.char_in;
                        last           <= chr.char_last;
                        color          <= chr.color_grb;
                        chr.char_ready <= 1'b0;
                        busy           <= 1'b1;
                        state          <= FETCH;
                    end
                end
                FETCH: begin
                    // rom_addr has been stable since accept, so rom_data is the glyph.
                    glyph   <= rom_data;
                    pix_cnt <= 6'd0;
                    bit_cnt <= 5'd23;
                    cyc_cnt <= '0;
                    led_out <= 1'b0;
                    state   <= SEND;
                end
                SEND: begin
                    // Registered output trails the counter by one cycle; each bit keeps its shape.
                    led_out <= (cyc_cnt < hi_lim);
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt != 5'd0) begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end else begin
                            bit_cnt <= 5'd23;
                            glyph   <= glyph >> 1;
                            pix_cnt <= pix_cnt + 6'd1;
                            if (pix_cnt == 6'd34) begin
                                if (last) begin
                                    state <= LATCH;
                                end else begin
                                    state          <= IDLE;
                                    chr.char_ready <= 1'b1;
                                    busy           <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    led_out <= 1'b0;
                    if (cyc_cnt == RST_END_V) begin
                        cyc_cnt        <= '0;
                        state          <= IDLE;
                        chr.char_ready <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
